// File: rtl/frame_binarizer_pkg.sv
// Shared definitions for the frame binarizer: image geometry, pixel format,
// threshold, image and counter types, and the capture FSM states.
package frame_binarizer_pkg;

  localparam int LENGTH = 32;   // image rows
  localparam int WIDTH  = 32;   // image columns (<= 32)
  localparam int PIX_W  = 8;    // grayscale sample width
  localparam int THRESH = 128;  // binarize threshold

  // Counter widths; a one-row or one-column image still gets a 1-bit counter.
  localparam int ROW_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;

  typedef logic [LENGTH-1:0][WIDTH-1:0] image_t;
  typedef logic [ROW_W-1:0]             row_t;
  typedef logic [COL_W-1:0]             col_t;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    HOLD
  } bin_state_t;

endpackage

// File: rtl/frame_binarizer_threshold.sv
// Combinational pixel binarizer: one grayscale sample in, one image bit out.
// bit = (pix >= THRESH) ^ INVERT
module pixel_threshold #(
  parameter int PIX_W  = 8,
  parameter int THRESH = 128,
  parameter bit INVERT = 1'b0
) (
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_bit
);

  // One extra bit so a threshold of 2**PIX_W (everything dark) is representable.
  localparam logic [PIX_W:0] THRESH_V = (PIX_W + 1)'(THRESH);

  assign pix_bit = ({1'b0, pix_data} >= THRESH_V) ^ INVERT;

endmodule

// File: rtl/frame_binarizer.sv
// Frame binarizer: captures a raster-order grayscale pixel stream into a
// LENGTH x WIDTH binary image, presents it with image_valid until the consumer
// acknowledges, then rearms for the next start-of-frame.
module frame_binarizer
  import frame_binarizer_pkg::*;
#(
  parameter int THRESH_P = frame_binarizer_pkg::THRESH,
  parameter bit INVERT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             pix_sof,
  input  logic [PIX_W-1:0] pix_data,
  output image_t           image,
  output logic             image_valid,
  input  logic             image_ack,
  output logic             frame_err
);

  localparam row_t ROW_LAST = row_t'(LENGTH - 1);
  localparam col_t COL_LAST = col_t'(WIDTH - 1);

  bin_state_t state_q, state_d;
  row_t       row_q, row_d;
  col_t       col_q, col_d;
  image_t     image_q, image_d;
  logic       frame_err_q, frame_err_d;

  logic pix_bit;
  logic transfer;
  logic sof_hit;
  logic wr_en;
  logic clear;
  logic last_pix;
  row_t wr_row;
  col_t wr_col;

  pixel_threshold #(
    .PIX_W  (PIX_W),
    .THRESH (THRESH_P),
    .INVERT (INVERT)
  ) u_threshold (
    .pix_data (pix_data),
    .pix_bit  (pix_bit)
  );

  // Stream handshake: the stage stalls only while an image is being held.
  assign pix_ready   = (state_q != HOLD);
  assign image_valid = (state_q == HOLD);
  assign image       = image_q;
  assign frame_err   = frame_err_q;
  assign transfer    = pix_valid & pix_ready;
  assign sof_hit     = transfer & pix_sof;

  // Write address: an accepted SOF always lands at [0][0], whatever the counters say.
  always_comb begin
    wr_row   = sof_hit ? '0 : row_q;
    wr_col   = sof_hit ? '0 : col_q;
    last_pix = (wr_row == ROW_LAST) && (wr_col == COL_LAST);
  end

  // Next-state, counter advance and image write control.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred; blocking '=' is used because this
    // is combinational logic evaluated top to bottom.
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    frame_err_d = frame_err_q;
    wr_en       = 1'b0;
    clear       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Pixels without SOF are dropped while waiting for a frame start.
        if (sof_hit) begin
          clear   = 1'b1;
          wr_en   = 1'b1;
          state_d = last_pix ? HOLD : CAPTURE;
        end
      end
      CAPTURE: begin
        if (transfer) begin
          if (pix_sof) begin
            // Early SOF aborts the partial frame and restarts at [0][0].
            frame_err_d = 1'b1;
            clear       = 1'b1;
          end
          wr_en = 1'b1;
          if (last_pix) state_d = HOLD;
        end
      end
      HOLD: begin
        if (image_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (wr_en) begin
      if (wr_col == COL_LAST) begin
        col_d = '0;
        row_d = (wr_row == ROW_LAST) ? '0 : wr_row + row_t'(1);
      end else begin
        col_d = wr_col + col_t'(1);
        row_d = wr_row;
      end
    end
  end

  // Image next value: clear on accepted SOF, then write the one addressed bit.
  always_comb begin
    image_d = clear ? '0 : image_q;
    if (wr_en) image_d[wr_row][wr_col] = pix_bit;
  end

  // State, counters, sticky error flag and image register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the image is an ordinary register bank, not a RAM, and it must read
    // as all zeros straight out of reset, so it is reset along with the FSM.
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      image_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking '<=' so every register samples pre-edge values.
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      image_q     <= image_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_frame_binarizer.sv
// Directed self-checking bench for frame_binarizer: full frames, threshold
// edges, stalls, hold/ack handshake, early SOF abort and mid-frame resets.
module tb_frame_binarizer;
  import frame_binarizer_pkg::*;

  localparam int NPIX = LENGTH * WIDTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pix_valid;
  logic             pix_ready;
  logic             pix_sof;
  logic [PIX_W-1:0] pix_data;
  image_t           image;
  logic             image_valid;
  logic             image_ack;
  logic             frame_err;

  int n_checks = 0;
  int n_pass   = 0;

  frame_binarizer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_sof     (pix_sof),
    .pix_data    (pix_data),
    .image       (image),
    .image_valid (image_valid),
    .image_ack   (image_ack),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Stimulus patterns: 0 = all 200, 1 = checkerboard, 2 = checkerboard with
  // threshold-edge values 127/128 at [0][0]/[0][1].
  function automatic logic [PIX_W-1:0] pix_of(input int kind, input int i, input int j);
    if (kind == 0) return 8'd200;
    if (kind == 2 && i == 0 && j == 0) return 8'd127;
    if (kind == 2 && i == 0 && j == 1) return 8'd128;
    return ((i + j) % 2 == 1) ? 8'd255 : 8'd0;
  endfunction

  // Hand-derived expected bits for the patterns above.
  function automatic image_t exp_image(input int kind);
    image_t e;
    for (int i = 0; i < LENGTH; i++)
      for (int j = 0; j < WIDTH; j++) begin
        if (kind == 0)                          e[i][j] = 1'b1;
        else if (kind == 2 && i == 0 && j == 0) e[i][j] = 1'b0;
        else if (kind == 2 && i == 0 && j == 1) e[i][j] = 1'b1;
        else                                    e[i][j] = ((i + j) % 2 == 1);
      end
    return e;
  endfunction

  function automatic logic [31:0] diff_bits(input image_t a, input image_t b);
    return 32'($countones(a ^ b));
  endfunction

  // Send raster pixels start..start+n-1; pixel 0 carries SOF. With gaps, idle
  // cycles (random data, random SOF without valid) are interleaved.
  task automatic send_pixels(input int kind, input int start, input int n, input bit gaps);
    for (int p = start; p < start + n; p++) begin
      if (gaps) begin
        while ($urandom % 2 == 1) begin
          pix_valid = 1'b0;
          pix_sof   = 1'($urandom % 2);
          pix_data  = PIX_W'($urandom);
          @(posedge clk); #1;
        end
      end
      pix_valid = 1'b1;
      pix_sof   = (p == 0);
      pix_data  = pix_of(kind, p / WIDTH, p % WIDTH);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic run_frame(input int kind, input bit gaps, input string tag);
    send_pixels(kind, 0, NPIX - 1, gaps);
    check({tag, "_valid_before_last"}, 32'(image_valid), 32'd0);
    send_pixels(kind, NPIX - 1, 1, gaps);
    check({tag, "_valid_after_last"}, 32'(image_valid), 32'd1);
    check({tag, "_ready_in_hold"}, 32'(pix_ready), 32'd0);
    check({tag, "_image_bad_bits"}, diff_bits(image, exp_image(kind)), 32'd0);
  endtask

  task automatic ack_pulse(input string tag);
    image_ack = 1'b1;
    @(posedge clk); #1;
    image_ack = 1'b0;
    check({tag, "_valid_after_ack"}, 32'(image_valid), 32'd0);
    check({tag, "_ready_after_ack"}, 32'(pix_ready), 32'd1);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    image_t held;
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = '0;
    image_ack = 1'b0;
    #12;
    check("rst_valid", 32'(image_valid), 32'd0);
    check("rst_ready", 32'(pix_ready), 32'd1);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_image_ones", diff_bits(image, '0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pixels and acks in IDLE without SOF are ignored.
    pix_valid = 1'b1; pix_data = 8'd200; image_ack = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    pix_valid = 1'b0; image_ack = 1'b0;
    check("idle_discard_image", diff_bits(image, '0), 32'd0);
    check("idle_discard_valid", 32'(image_valid), 32'd0);

    // Full bright frame, one pixel per cycle.
    run_frame(0, 1'b0, "bright");

    // Hold: stream pushes for 20 cycles, image must stay frozen.
    held = image;
    pix_valid = 1'b1;
    pix_data  = 8'd0;
    for (int c = 0; c < 20; c++) begin
      pix_sof = c[0];
      @(posedge clk); #1;
      check("hold_ready_low", 32'(pix_ready), 32'd0);
    end
    pix_valid = 1'b0; pix_sof = 1'b0;
    check("hold_valid_kept", 32'(image_valid), 32'd1);
    check("hold_image_frozen", diff_bits(image, held), 32'd0);
    ack_pulse("hold");
    check("idle_image_retained", diff_bits(image, exp_image(0)), 32'd0);

    // Checkerboard with threshold-edge pixels, gap-free then with gaps.
    run_frame(2, 1'b0, "checker");
    check("thresh_127", 32'(image[0][0]), 32'd0);
    check("thresh_128", 32'(image[0][1]), 32'd1);
    ack_pulse("checker");
    run_frame(2, 1'b1, "gaps");
    ack_pulse("gaps");

    // Early SOF at pixel 500 aborts and restarts the frame.
    check("err_before_abort", 32'(frame_err), 32'd0);
    send_pixels(0, 0, 500, 1'b0);
    check("abort_partial_valid", 32'(image_valid), 32'd0);
    send_pixels(1, 0, 1, 1'b0);
    check("abort_err_set", 32'(frame_err), 32'd1);
    check("abort_image_cleared", diff_bits(image, '0), 32'd0);
    send_pixels(1, 1, NPIX - 2, 1'b0);
    check("abort_valid_before_last", 32'(image_valid), 32'd0);
    send_pixels(1, NPIX - 1, 1, 1'b0);
    check("abort_valid_after_last", 32'(image_valid), 32'd1);
    check("abort_image_bad_bits", diff_bits(image, exp_image(1)), 32'd0);
    ack_pulse("abort");
    check("err_sticky", 32'(frame_err), 32'd1);

    // Reset at pixel 300 of a frame.
    send_pixels(0, 0, 300, 1'b0);
    async_reset();
    check("rst300_valid", 32'(image_valid), 32'd0);
    check("rst300_image", diff_bits(image, '0), 32'd0);
    check("rst300_err", 32'(frame_err), 32'd0);
    release_reset();
    run_frame(1, 1'b0, "after_rst300");

    // Reset while holding.
    async_reset();
    check("rsthold_valid", 32'(image_valid), 32'd0);
    check("rsthold_image", diff_bits(image, '0), 32'd0);
    check("rsthold_ready", 32'(pix_ready), 32'd1);
    release_reset();
    run_frame(2, 1'b0, "after_rsthold");
    ack_pulse("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
